// File: rtl/apb_pkg.sv
// Shared types and parameter helpers for the APB memory slave.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package apb_pkg;

  // Transfer FSM: IDLE waits for a setup cycle, ACCESS runs wait states and completion.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  // Number of byte lanes on a data_w-bit bus.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-address bits below the word index.
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // True when the parameter set describes a buildable slave.
  function automatic bit params_ok(input int data_w, input int addr_w,
                                   input int depth, input int wait_cycles);
    bit width_ok;
    width_ok = (data_w == 8) || (data_w == 16) || (data_w == 32) || (data_w == 64);
    if (!width_ok) return 1'b0;
    if (addr_w <= addr_lsb(data_w)) return 1'b0;
    if (addr_w - addr_lsb(data_w) > 30) return 1'b0;
    if (depth < 1) return 1'b0;
    if (depth > (1 << (addr_w - addr_lsb(data_w)))) return 1'b0;
    return wait_cycles >= 0;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word storage with byte-strobe write and combinational read.
// Latency: write lands on the clock edge; read data is combinational from idx.
// Backpressure: none; the owner gates we.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0] rdata
);

  localparam int STRB_W = strb_w(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear every word on reset; otherwise update only the strobed byte lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Indices past DEPTH (non power-of-two depths) read as zero rather than X.
  assign rdata = (32'(idx) < DEPTH) ? mem_q[idx] : '0;

endmodule

// File: rtl/apb_mem_slave.sv
// APB scratch memory slave with byte strobes, wait states and address-error response.
// Latency: 2+WAIT_CYCLES cycles from setup to completion inclusive.
// Backpressure: pready held low for WAIT_CYCLES access cycles; psel drop aborts.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int LSB    = addr_lsb(DATA_W);
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((1 << LSB) - 1);

  if (!params_ok(DATA_W, ADDR_W, DEPTH, WAIT_CYCLES)) begin : g_param_check
    $error("apb_mem_slave: illegal DATA_W/ADDR_W/DEPTH/WAIT_CYCLES combination");
  end

  apb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                pready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;

  logic                setup;
  logic                complete;
  logic                leave_access;
  logic [ADDR_W-1:0]   word_idx;
  logic                misaligned;
  logic                out_of_range;
  logic                addr_err;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus setup/completion strobes; psel+penable in IDLE is ignored.
  always_comb begin
    state_d      = state_q;
    setup        = 1'b0;
    complete     = 1'b0;
    leave_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          setup   = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d      = IDLE;
          leave_access = 1'b1;
        end else if (penable && pready_q) begin
          state_d      = IDLE;
          complete     = 1'b1;
          leave_access = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait-state counter; pready is precomputed one cycle ahead so it comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      pready_q <= 1'b0;
    end else if (setup) begin
      cnt_q    <= CNT_W'(WAIT_CYCLES);
      pready_q <= (WAIT_CYCLES == 0);
    end else if (leave_access) begin
      cnt_q    <= '0;
      pready_q <= 1'b0;
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_q    <= cnt_q - 1'b1;
      pready_q <= (cnt_q == CNT_W'(1));
    end
  end

  // Capture the request at setup; bus changes during ACCESS are deliberately ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (setup) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

  assign word_idx     = addr_q >> LSB;
  assign misaligned   = (addr_q & LSB_MASK) != '0;
  assign out_of_range = 32'(word_idx) >= DEPTH;
  assign addr_err     = misaligned || out_of_range;

  // A bad address never touches storage, even with strobes set.
  assign mem_we = complete && write_q && !addr_err;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .idx   (word_idx[AW-1:0]),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .rdata (mem_rdata)
  );

  assign pready  = pready_q;
  assign pslverr = complete && addr_err;
  assign prdata  = (complete && !write_q && !addr_err) ? mem_rdata : '0;

endmodule
